// File: rtl/vproc_elem_res_pack.sv
// rtl/vproc_elem_res_pack.sv - packs ELEM unit element results into vreg writes, forwards scalar results
module vproc_elem_res_pack #(
  parameter int unsigned VREG_W         = 128,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic                clk_i,
  input  logic                async_rst_ni,
  input  logic                pipe_in_valid_i,
  output logic                pipe_in_ready_o,
  input  logic                pipe_in_first_i,
  input  logic                pipe_in_last_i,
  input  logic [1:0]          pipe_in_eew_i,
  input  logic [4:0]          pipe_in_vaddr_i,
  input  logic                pipe_in_res_valid_i,
  input  logic [31:0]         pipe_in_res_i,
  input  logic [3:0]          pipe_in_mask_i,
  input  logic                pipe_in_xreg_valid_i,
  input  logic [31:0]         pipe_in_xreg_data_i,
  input  logic [4:0]          pipe_in_xreg_addr_i,
  output logic                vreg_wr_valid_o,
  input  logic                vreg_wr_ready_i,
  output logic [4:0]          vreg_wr_addr_o,
  output logic [VREG_W-1:0]   vreg_wr_data_o,
  output logic [VREG_W/8-1:0] vreg_wr_be_o,
  output logic                xreg_valid_o,
  input  logic                xreg_ready_i,
  output logic [4:0]          xreg_addr_o,
  output logic [31:0]         xreg_data_o
);

  localparam int unsigned NB = VREG_W / 8;
  localparam int unsigned PW = $clog2(NB);

  logic [VREG_W-1:0] buf_q, buf_d, res_sh, bit_sel;
  logic [NB-1:0]     be_q, be_b, be_d, byte_sel, lane_mask;
  logic [PW-1:0]     ptr_q, ptr_b, ptr_d;
  logic [2:0]        grp_q, grp_b, bytes;
  logic [4:0]        vaddr_q, vaddr_b, wr_addr;
  logic [1:0]        eew_q, eew_b;
  logic [31:0]       res_m;
  logic              do_pack, fill, emit, acc;

  logic              vreg_pend_q, xreg_pend_q;
  logic [4:0]        vreg_addr_q, xreg_addr_q;
  logic [VREG_W-1:0] vreg_data_q;
  logic [NB-1:0]     vreg_be_q;
  logic [31:0]       xreg_data_q;

  logic unused_mask;
  assign unused_mask = ^pipe_in_mask_i[3:1];

  assign pipe_in_ready_o = (~vreg_pend_q | vreg_wr_ready_i) & (~xreg_pend_q | xreg_ready_i);
  assign acc             = pipe_in_valid_i & pipe_in_ready_o;

  // A first beat restarts packing from a clean buffer before its own element lands.
  always_comb begin
    eew_b     = pipe_in_first_i ? pipe_in_eew_i   : eew_q;
    vaddr_b   = pipe_in_first_i ? pipe_in_vaddr_i : vaddr_q;
    grp_b     = pipe_in_first_i ? 3'd0            : grp_q;
    ptr_b     = pipe_in_first_i ? '0              : ptr_q;
    be_b      = pipe_in_first_i ? '0              : be_q;
    bytes     = 3'd0;
    lane_mask = '0;
    res_m     = '0;
    case (eew_b)
      2'b00: begin bytes = 3'd1; lane_mask = NB'(4'h1); res_m = {24'd0, pipe_in_res_i[7:0]};  end
      2'b01: begin bytes = 3'd2; lane_mask = NB'(4'h3); res_m = {16'd0, pipe_in_res_i[15:0]}; end
      2'b10: begin bytes = 3'd4; lane_mask = NB'(4'hF); res_m = pipe_in_res_i;                end
      default: ;
    endcase
    do_pack  = pipe_in_res_valid_i & (bytes != 3'd0);
    ptr_d    = do_pack ? ptr_b + PW'(bytes) : ptr_b;
    byte_sel = do_pack ? (lane_mask << ptr_b) : '0;
    res_sh   = VREG_W'(res_m) << {ptr_b, 3'b000};
    bit_sel  = '0;
    for (int b = 0; b < int'(NB); b++) begin
      bit_sel[8*b +: 8] = {8{byte_sel[b]}};
    end
    buf_d   = (buf_q & ~bit_sel) | (res_sh & bit_sel);
    be_d    = (be_b & ~byte_sel) | (byte_sel & {NB{pipe_in_mask_i[0]}});
    fill    = do_pack & (ptr_d == '0);
    emit    = fill | (pipe_in_last_i & (ptr_d != '0));
    wr_addr = vaddr_b + {2'b00, grp_b};
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      buf_q       <= '0;
      be_q        <= '0;
      ptr_q       <= '0;
      grp_q       <= '0;
      vaddr_q     <= '0;
      eew_q       <= '0;
      vreg_pend_q <= 1'b0;
      vreg_addr_q <= '0;
      vreg_data_q <= '0;
      vreg_be_q   <= '0;
      xreg_pend_q <= 1'b0;
      xreg_addr_q <= '0;
      xreg_data_q <= '0;
    end else begin
      if (acc) begin
        buf_q   <= buf_d;
        be_q    <= emit ? '0 : be_d;
        ptr_q   <= ptr_d;
        grp_q   <= emit ? grp_b + 3'd1 : grp_b;
        vaddr_q <= vaddr_b;
        eew_q   <= eew_b;
      end
      if (acc && emit) begin
        vreg_pend_q <= 1'b1;
        vreg_addr_q <= wr_addr;
        vreg_data_q <= buf_d;
        vreg_be_q   <= be_d;
      end else if (vreg_wr_ready_i) begin
        vreg_pend_q <= 1'b0;
      end
      if (acc && pipe_in_xreg_valid_i) begin
        xreg_pend_q <= 1'b1;
        xreg_addr_q <= pipe_in_xreg_addr_i;
        xreg_data_q <= pipe_in_xreg_data_i;
      end else if (xreg_ready_i) begin
        xreg_pend_q <= 1'b0;
      end
    end
  end

  assign vreg_wr_valid_o = vreg_pend_q;
  assign vreg_wr_addr_o  = (DONT_CARE_ZERO && !vreg_pend_q) ? '0 : vreg_addr_q;
  assign vreg_wr_data_o  = (DONT_CARE_ZERO && !vreg_pend_q) ? '0 : vreg_data_q;
  assign vreg_wr_be_o    = vreg_pend_q ? vreg_be_q : '0;
  assign xreg_valid_o    = xreg_pend_q;
  assign xreg_addr_o     = (DONT_CARE_ZERO && !xreg_pend_q) ? '0 : xreg_addr_q;
  assign xreg_data_o     = (DONT_CARE_ZERO && !xreg_pend_q) ? '0 : xreg_data_q;

endmodule

// File: tb/tb_vproc_elem_res_pack.sv
// tb/tb_vproc_elem_res_pack.sv - scoreboard bench for vproc_elem_res_pack
module tb_vproc_elem_res_pack;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pipe_in_valid_i, pipe_in_ready_o, pipe_in_first_i, pipe_in_last_i;
  logic [1:0]   pipe_in_eew_i;
  logic [4:0]   pipe_in_vaddr_i;
  logic         pipe_in_res_valid_i;
  logic [31:0]  pipe_in_res_i;
  logic [3:0]   pipe_in_mask_i;
  logic         pipe_in_xreg_valid_i;
  logic [31:0]  pipe_in_xreg_data_i;
  logic [4:0]   pipe_in_xreg_addr_i;
  logic         vreg_wr_valid_o, vreg_wr_ready_i;
  logic [4:0]   vreg_wr_addr_o;
  logic [127:0] vreg_wr_data_o;
  logic [15:0]  vreg_wr_be_o;
  logic         xreg_valid_o, xreg_ready_i;
  logic [4:0]   xreg_addr_o;
  logic [31:0]  xreg_data_o;

  typedef struct {
    logic [4:0]   a;
    logic [127:0] d;
    logic [15:0]  be;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;

  vproc_elem_res_pack #(.VREG_W(128), .DONT_CARE_ZERO(1'b1)) dut (
    .clk_i(clk), .async_rst_ni(rst_n),
    .pipe_in_valid_i(pipe_in_valid_i), .pipe_in_ready_o(pipe_in_ready_o),
    .pipe_in_first_i(pipe_in_first_i), .pipe_in_last_i(pipe_in_last_i),
    .pipe_in_eew_i(pipe_in_eew_i), .pipe_in_vaddr_i(pipe_in_vaddr_i),
    .pipe_in_res_valid_i(pipe_in_res_valid_i), .pipe_in_res_i(pipe_in_res_i),
    .pipe_in_mask_i(pipe_in_mask_i), .pipe_in_xreg_valid_i(pipe_in_xreg_valid_i),
    .pipe_in_xreg_data_i(pipe_in_xreg_data_i), .pipe_in_xreg_addr_i(pipe_in_xreg_addr_i),
    .vreg_wr_valid_o(vreg_wr_valid_o), .vreg_wr_ready_i(vreg_wr_ready_i),
    .vreg_wr_addr_o(vreg_wr_addr_o), .vreg_wr_data_o(vreg_wr_data_o), .vreg_wr_be_o(vreg_wr_be_o),
    .xreg_valid_o(xreg_valid_o), .xreg_ready_i(xreg_ready_i),
    .xreg_addr_o(xreg_addr_o), .xreg_data_o(xreg_data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every handshaken vreg write is compared against the oldest expected write.
  always begin
    wr_t          e;
    logic [127:0] m;
    @(negedge clk);
    #2;
    if (rst_n && vreg_wr_valid_o && vreg_wr_ready_i) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL vreg_write_unexpected: got addr %0d data %h be %h, required none", vreg_wr_addr_o, vreg_wr_data_o, vreg_wr_be_o);
      end else begin
        e = q.pop_front();
        m = '0;
        for (int b = 0; b < 16; b++) m[8*b +: 8] = {8{e.be[b]}};
        if (vreg_wr_addr_o !== e.a || vreg_wr_be_o !== e.be || (vreg_wr_data_o & m) !== (e.d & m)) begin
          errors++;
          $display("FAIL vreg_write: got addr %0d data %h be %h, required addr %0d data %h be %h",
                   vreg_wr_addr_o, vreg_wr_data_o & m, vreg_wr_be_o, e.a, e.d & m, e.be);
        end
      end
    end
  end

  task automatic push_wr(input logic [4:0] a, input logic [127:0] d, input logic [15:0] be);
    wr_t e;
    e.a = a; e.d = d; e.be = be;
    q.push_back(e);
  endtask

  task automatic send_beat(input logic first, input logic last, input logic [1:0] eew, input logic [4:0] va,
                           input logic rv, input logic [31:0] res, input logic [3:0] mask,
                           input logic xv, input logic [31:0] xd, input logic [4:0] xa);
    int n;
    @(negedge clk);
    pipe_in_valid_i = 1'b1; pipe_in_first_i = first; pipe_in_last_i = last;
    pipe_in_eew_i = eew; pipe_in_vaddr_i = va; pipe_in_res_valid_i = rv;
    pipe_in_res_i = res; pipe_in_mask_i = mask;
    pipe_in_xreg_valid_i = xv; pipe_in_xreg_data_i = xd; pipe_in_xreg_addr_i = xa;
    n = 0;
    #1;
    while (pipe_in_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL send_beat_timeout: ready stuck at %b, required 1", pipe_in_ready_o);
    end
    @(posedge clk);
    #1;
    pipe_in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, q.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pipe_in_valid_i = 0; pipe_in_first_i = 0; pipe_in_last_i = 0; pipe_in_eew_i = 0;
    pipe_in_vaddr_i = 0; pipe_in_res_valid_i = 0; pipe_in_res_i = 0; pipe_in_mask_i = 0;
    pipe_in_xreg_valid_i = 0; pipe_in_xreg_data_i = 0; pipe_in_xreg_addr_i = 0;
    vreg_wr_ready_i = 1; xreg_ready_i = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (vreg_wr_valid_o !== 1'b0 || xreg_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: got vreg %b xreg %b, required 0 0", vreg_wr_valid_o, xreg_valid_o);
    end
    checks++;
    if (pipe_in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", pipe_in_ready_o);
    end
    checks++;
    if (vreg_wr_data_o !== '0 || vreg_wr_be_o !== '0 || xreg_data_o !== '0) begin
      errors++;
      $display("FAIL reset_data: got data %h be %h xdata %h, required zeros", vreg_wr_data_o, vreg_wr_be_o, xreg_data_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_eew32;
    logic [31:0] v;
    push_wr(5'd8, 128'h44444444_33333333_22222222_11111111, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      v = 32'h11111111 * (i + 1);
      send_beat(i == 0, i == 3, 2'b10, 5'd8, 1'b1, v, 4'hF, 1'b0, 32'd0, 5'd0);
      if (i == 2) begin
        checks++;
        if (vreg_wr_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL eew32_early_write: valid %b, required 0", vreg_wr_valid_o);
        end
      end
    end
    checks++;
    if (vreg_wr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL eew32_latency: valid %b one cycle after last accept, required 1", vreg_wr_valid_o);
    end
    wait_drain("eew32");
  endtask

  task automatic test_eew8;
    logic [127:0] d = '0;
    for (int i = 0; i < 6; i++) d[8*i +: 8] = 8'hA0 + 8'(i);
    push_wr(5'd3, d, 16'h003F);
    for (int i = 0; i < 6; i++)
      send_beat(i == 0, i == 5, 2'b00, 5'd3, 1'b1, {24'h5A5A5A, 8'hA0 + 8'(i)}, 4'h1, 1'b0, 32'd0, 5'd0);
    wait_drain("eew8");
  endtask

  task automatic test_eew16_mask;
    logic [127:0] d0 = '0, d1 = '0;
    for (int i = 0; i < 8; i++) d0[16*i +: 16] = 16'hC000 + 16'(i);
    d1[15:0]  = 16'hC008;
    d1[31:16] = 16'hC009;
    push_wr(5'd30, d0, 16'hFFF3);
    push_wr(5'd31, d1, 16'h000F);
    for (int i = 0; i < 10; i++)
      send_beat(i == 0, i == 9, 2'b01, 5'd30, 1'b1, {16'hFFFF, 16'hC000 + 16'(i)},
                (i == 1) ? 4'hE : 4'hF, 1'b0, 32'd0, 5'd0);
    wait_drain("eew16");
  endtask

  task automatic test_res_gap;
    push_wr(5'd1, {32'hD0000005, 32'hD0000004, 32'hD0000003, 32'hD0000000}, 16'hFFFF);
    for (int i = 0; i < 6; i++)
      send_beat(i == 0, i == 5, 2'b10, 5'd1, !(i == 1 || i == 2), 32'hD0000000 + 32'(i), 4'hF, 1'b0, 32'd0, 5'd0);
    wait_drain("res_gap");
  endtask

  task automatic test_back_to_back;
    logic [127:0] d0 = {32'hE0000003, 32'hE0000002, 32'hE0000001, 32'hE0000000};
    push_wr(5'd12, d0, 16'hFFFF);
    push_wr(5'd13, {32'hE0000007, 32'hE0000006, 32'hE0000005, 32'hE0000004}, 16'hFFFF);
    vreg_wr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send_beat(i == 0, 1'b0, 2'b10, 5'd12, 1'b1, 32'hE0000000 + 32'(i), 4'hF, 1'b0, 32'd0, 5'd0);
    fork
      begin
        for (int i = 4; i < 8; i++)
          send_beat(1'b0, i == 7, 2'b10, 5'd12, 1'b1, 32'hE0000000 + 32'(i), 4'hF, 1'b0, 32'd0, 5'd0);
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          #2;
          checks++;
          if (pipe_in_ready_o !== 1'b0 || vreg_wr_valid_o !== 1'b1 || vreg_wr_data_o !== d0 || vreg_wr_addr_o !== 5'd12) begin
            errors++;
            $display("FAIL stall_hold: ready %b valid %b addr %0d data %h, required 0 1 12 %h",
                     pipe_in_ready_o, vreg_wr_valid_o, vreg_wr_addr_o, vreg_wr_data_o, d0);
          end
        end
        @(negedge clk);
        vreg_wr_ready_i = 1'b1;
      end
    join
    wait_drain("back_to_back");
  endtask

  task automatic test_xreg;
    xreg_ready_i = 1'b0;
    send_beat(1'b0, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0, 4'h0, 1'b1, 32'hCAFEBABE, 5'd5);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (xreg_valid_o !== 1'b1 || xreg_data_o !== 32'hCAFEBABE || xreg_addr_o !== 5'd5) begin
        errors++;
        $display("FAIL xreg_hold: valid %b data %h addr %0d, required 1 cafebabe 5", xreg_valid_o, xreg_data_o, xreg_addr_o);
      end
      @(negedge clk);
      #2;
    end
    xreg_ready_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (xreg_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL xreg_clear: valid %b, required 0", xreg_valid_o);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] d = '0;
    push_wr(5'd20, {32'hF0000003, 32'hF0000002, 32'hF0000001, 32'hF0000000}, 16'hFFFF);
    xreg_ready_i = 1'b0;
    for (int i = 0; i < 6; i++)
      send_beat(i == 0, 1'b0, 2'b10, 5'd20, 1'b1, 32'hF0000000 + 32'(i), 4'hF, i == 5, 32'h12345678, 5'd7);
    wait_drain("reset_mid_pre");
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (vreg_wr_valid_o !== 1'b0 || xreg_valid_o !== 1'b0 || xreg_data_o !== '0) begin
      errors++;
      $display("FAIL async_reset: vreg %b xreg %b xdata %h, required 0 0 0", vreg_wr_valid_o, xreg_valid_o, xreg_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    xreg_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) d[16*i +: 16] = 16'hB000 + 16'(i);
    push_wr(5'd25, d, 16'h003F);
    for (int i = 0; i < 3; i++)
      send_beat(i == 0, i == 2, 2'b01, 5'd25, 1'b1, 32'h0000B000 + 32'(i), 4'hF, 1'b0, 32'd0, 5'd0);
    wait_drain("reset_mid_post");
  endtask

  initial begin
    test_reset();
    test_eew32();
    test_eew8();
    test_eew16_mask();
    test_res_gap();
    test_back_to_back();
    test_xreg();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d writes outstanding, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
